// File: rtl/sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_responder_pkg
// Shared definitions for the SRAM responder: FSM state encoding, the LFSR seed
// and feedback tap mask, and the LFSR next-state helper.
// Optional feature macro used by the files importing this package:
//   SRAM_WAIT_STATE_EN - enables pseudo-random wait states.
// -----------------------------------------------------------------------------
package sram_responder_pkg;

  // Responder states. WAIT is only reachable when wait states are enabled.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_SEED     = 8'hA5;
  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3).
  localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

  // Fibonacci step: shift left, new LSB is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/sram_lfsr8.sv
// -----------------------------------------------------------------------------
// sram_lfsr8
// 8-bit Fibonacci LFSR that free-runs every cycle once reset is released.
// Used to pick the number of wait states per access.
// Ports:
//   clk   - clock, state advances on rising edge
//   rst_n - asynchronous active-low reset, reloads the seed
//   value - current LFSR contents
// -----------------------------------------------------------------------------
module sram_lfsr8
  import sram_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value
);

  // Advance one step per cycle; reset restores the shared seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Single-port word SRAM with byte-lane writes behind a request/ready handshake.
// An accepted request completes with a one-cycle sram_ready pulse; the array
// write or read happens on the edge that enters RESP.
// Configuration macro:
//   SRAM_WAIT_STATE_EN - when defined, each access waits 0..3 extra cycles
//                        chosen by an LFSR; otherwise latency is one cycle.
// Parameters:
//   ADDR_W     - word-address bits (2^ADDR_W 32-bit words)
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   sram_en    - access request
//   sram_we    - byte write strobes, all zero means read
//   sram_addr  - byte address, word index is sram_addr[ADDR_W+1:2]
//   sram_wdata - write data
//   sram_rdata - registered read data
//   sram_ready - one-cycle completion pulse
// -----------------------------------------------------------------------------
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        sram_ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [0:DEPTH-1];
  state_t            state;
  logic [3:0]        req_we;
  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       req_wdata;

  logic [ADDR_W-1:0] in_idx;
  logic              accept;
  logic              commit;
  logic [3:0]        commit_we;
  logic [ADDR_W-1:0] commit_idx;
  logic [31:0]       commit_wdata;

  // Address bits above the word index alias; byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sram_addr[31:ADDR_W+2], sram_addr[1:0]};

  assign in_idx = sram_addr[ADDR_W+1:2];
  assign accept = sram_en && (state != WAIT);

`ifdef SRAM_WAIT_STATE_EN
  logic [7:0] lfsr;
  logic [1:0] wait_cnt;

  sram_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr)
  );

  // An access commits either straight from the inputs (zero wait states)
  // or from the captured request when the wait countdown expires.
  always_comb begin
    commit       = 1'b0;
    commit_we    = sram_we;
    commit_idx   = in_idx;
    commit_wdata = sram_wdata;
    if (state == WAIT) begin
      if (wait_cnt == 2'd1) begin
        commit       = 1'b1;
        commit_we    = req_we;
        commit_idx   = req_idx;
        commit_wdata = req_wdata;
      end
    end else if (accept && lfsr[1:0] == 2'b00) begin
      commit = 1'b1;
    end
  end
`else
  // Without wait states every accepted request commits immediately, so the
  // request registers are captured but never needed by the datapath.
  logic unused_req;
  assign unused_req = ^{req_we, req_idx, req_wdata};

  always_comb begin
    commit       = accept;
    commit_we    = sram_we;
    commit_idx   = in_idx;
    commit_wdata = sram_wdata;
  end
`endif

  // Array write with per-lane enables. Not reset; the rst_n gate keeps a
  // clock edge during reset from committing anything.
  always_ff @(posedge clk) begin
    if (commit && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_we[i]) begin
          mem[commit_idx][8*i +: 8] <= commit_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered ready/rdata. sram_ready is high exactly in
  // RESP because RESP is entered only on a commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sram_ready <= 1'b0;
      sram_rdata <= 32'h0;
      req_we     <= 4'h0;
      req_idx    <= '0;
      req_wdata  <= 32'h0;
`ifdef SRAM_WAIT_STATE_EN
      wait_cnt   <= 2'd0;
`endif
    end else begin
      sram_ready <= commit;
      if (commit && commit_we == 4'h0) begin
        sram_rdata <= mem[commit_idx];
      end
      if (accept) begin
        req_we    <= sram_we;
        req_idx   <= in_idx;
        req_wdata <= sram_wdata;
      end
`ifdef SRAM_WAIT_STATE_EN
      case (state)
        WAIT: begin
          if (wait_cnt == 2'd1) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: begin
          if (!sram_en) begin
            state <= IDLE;
          end else if (lfsr[1:0] == 2'b00) begin
            state <= RESP;
          end else begin
            state    <= WAIT;
            wait_cnt <= lfsr[1:0];
          end
        end
      endcase
`else
      state <= commit ? RESP : IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
// Directed self-checking bench for sram_responder. With SRAM_WAIT_STATE_EN
// defined it also runs a random scoreboard pass and a reset-during-wait case.
// -----------------------------------------------------------------------------
module tb_sram_responder;

  logic        clk;
  logic        rst_n;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat;
  int c0, c1, c2;

  sram_responder #(.ADDR_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  // 10 ns clock with a free-running cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request and wait (bounded) for its ready pulse; leaves sram_en
  // high so a following call forms a back-to-back access.
  task automatic applyStimulus(input logic [31:0] a, input logic [3:0] we,
                               input logic [31:0] d, output int latency);
    @(negedge clk);
    sram_en = 1'b1; sram_addr = a; sram_we = we; sram_wdata = d;
    latency = 0;
    do begin
      @(posedge clk); #1;
      latency++;
    end while (!sram_ready && latency < 8);
    if (!sram_ready) checkOutput("ready_timeout", {31'b0, sram_ready}, 32'h1);
  endtask

  task automatic endAccess();
    @(negedge clk);
    sram_en = 1'b0; sram_we = 4'h0;
  endtask

  // Expected latency is exactly one cycle without wait states, 1..4 with.
  task automatic checkLatency(input string tag, input int l);
`ifdef SRAM_WAIT_STATE_EN
    checkOutput(tag, {31'b0, (l >= 1 && l <= 4)}, 32'h1);
`else
    checkOutput(tag, l, 32'd1);
`endif
  endtask

`ifdef SRAM_WAIT_STATE_EN
  logic [31:0] model [0:7];
  logic [31:0] rnd_d, merged;
  logic [3:0]  rnd_we;
  int          k;
  bit          hit_wait;
`endif

  initial begin
    rst_n = 1'b0; sram_en = 1'b0; sram_we = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    #1;
    checkOutput("reset_ready", {31'b0, sram_ready}, 32'h0);
    checkOutput("reset_rdata", sram_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full write then read.
    applyStimulus(32'h10, 4'b1111, 32'hDEADBEEF, lat);
    checkLatency("wr_lat", lat);
    checkOutput("wr_keeps_rdata", sram_rdata, 32'h0);
    applyStimulus(32'h10, 4'b0000, 32'h0, lat);
    checkLatency("rd_lat", lat);
    checkOutput("rd_full", sram_rdata, 32'hDEADBEEF);
    endAccess();
    @(posedge clk); #1;
    checkOutput("idle_ready_low", {31'b0, sram_ready}, 32'h0);
    checkOutput("idle_rdata_hold", sram_rdata, 32'hDEADBEEF);

    // Single-lane write merges into the existing word.
    applyStimulus(32'h10, 4'b0010, 32'h0000AA00, lat);
    checkOutput("lane_wr_keeps_rdata", sram_rdata, 32'hDEADBEEF);
    applyStimulus(32'h10, 4'b0000, 32'h0, lat);
    checkOutput("rd_lane", sram_rdata, 32'hDEADAAEF);

    // Fill three words, then back-to-back reads.
    applyStimulus(32'h0, 4'b1111, 32'h11111111, lat);
    applyStimulus(32'h4, 4'b1111, 32'h22222222, lat);
    applyStimulus(32'h8, 4'b1111, 32'h33333333, lat);
    applyStimulus(32'h0, 4'b0000, 32'h0, lat);
    c0 = cyc;
    checkOutput("b2b_rd0", sram_rdata, 32'h11111111);
    applyStimulus(32'h4, 4'b0000, 32'h0, lat);
    c1 = cyc;
    checkOutput("b2b_rd1", sram_rdata, 32'h22222222);
    applyStimulus(32'h8, 4'b0000, 32'h0, lat);
    c2 = cyc;
    checkOutput("b2b_rd2", sram_rdata, 32'h33333333);
`ifndef SRAM_WAIT_STATE_EN
    checkOutput("b2b_gap01", c1 - c0, 32'd1);
    checkOutput("b2b_gap12", c2 - c1, 32'd1);
`endif

    // Upper address bits alias onto the low words.
    applyStimulus(32'h4000, 4'b0000, 32'h0, lat);
    checkOutput("alias_rd", sram_rdata, 32'h11111111);
    applyStimulus(32'h4007, 4'b1111, 32'hCAFEF00D, lat);
    applyStimulus(32'h4, 4'b0000, 32'h0, lat);
    checkOutput("alias_wr", sram_rdata, 32'hCAFEF00D);

    // Write immediately followed by read of the same word.
    applyStimulus(32'h20, 4'b1111, 32'h12345678, lat);
    applyStimulus(32'h20, 4'b0000, 32'h0, lat);
    checkOutput("raw_same_word", sram_rdata, 32'h12345678);
    endAccess();

    // Asynchronous reset clears outputs but not the array.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rdata", sram_rdata, 32'h0);
    checkOutput("async_rst_ready", {31'b0, sram_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h20, 4'b0000, 32'h0, lat);
    checkOutput("array_survives_rst", sram_rdata, 32'h12345678);
    endAccess();

`ifdef SRAM_WAIT_STATE_EN
    // Random accesses over eight words against a scoreboard.
    for (int i = 0; i < 8; i++) begin
      model[i] = 32'h5A000000 | i;
      applyStimulus(32'h100 + 4*i, 4'b1111, model[i], lat);
    end
    for (int i = 0; i < 100; i++) begin
      k      = $urandom_range(0, 7);
      rnd_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rnd_d  = $urandom;
      applyStimulus(32'h100 + 4*k, rnd_we, rnd_d, lat);
      checkLatency("rand_lat", lat);
      if (rnd_we == 4'h0) begin
        checkOutput("rand_rd", sram_rdata, model[k]);
      end else begin
        merged = model[k];
        for (int b = 0; b < 4; b++) if (rnd_we[b]) merged[8*b +: 8] = rnd_d[8*b +: 8];
        model[k] = merged;
      end
    end
    endAccess();

    // Reset while a write to 0x20 sits in WAIT; it must never land.
    hit_wait = 1'b0;
    for (int t = 0; t < 20 && !hit_wait; t++) begin
      @(negedge clk);
      sram_en = 1'b1; sram_addr = 32'h20; sram_we = 4'b1111; sram_wdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      if (!sram_ready) begin
        hit_wait = 1'b1;
        rst_n = 1'b0;
        #1;
        sram_en = 1'b0; sram_we = 4'h0;
        checkOutput("wait_rst_rdata", sram_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        endAccess();
        applyStimulus(32'h20, 4'b1111, 32'h12345678, lat);
        endAccess();
      end
    end
    checkOutput("wait_state_seen", {31'b0, hit_wait}, 32'h1);
    applyStimulus(32'h20, 4'b0000, 32'h0, lat);
    checkOutput("wait_rst_no_write", sram_rdata, 32'h12345678);
    endAccess();
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
